p_controller_pwm: RTL

Proportional controller stage that sits directly downstream of `spi_mcp3202_interface`. It takes each 12-bit ADC sample announced by `reading_valid` and computes a duty cycle: a bias plus the scaled error between the setpoint and the sample. It then drives a glitch-free, period-aligned PWM output to the actuator.

---
 rtl/p_controller_pwm.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/p_controller_pwm.sv
`default_nettype none
// ============================================================================
// Module   : p_controller_pwm
// Purpose  : Proportional controller feeding a period-aligned PWM generator.
//            Each rising edge of reading_valid captures one ADC sample. A
//            four-register pipeline (error, product, biased sum, saturated
//            duty) produces a new duty value 3 cycles after the capture edge.
//            The PWM stage only adopts a new duty at the period wrap, so the
//            waveform never glitches mid-period.
// Ports    : sys_clk        - single clock
//            sys_reset_n    - asynchronous active-low reset
//            sensor_reading - 12-bit unsigned ADC sample
//            reading_valid  - sample strobe, captured on its rising edge
//            setpoint       - 12-bit unsigned target
//            kp             - 8-bit unsigned gain (scale 2^-KP_SHIFT)
//            duty           - latest computed duty (PWM_W bits)
//            duty_valid     - one-cycle pulse when duty updates
//            pwm_out        - registered PWM waveform
// Config   : define P_CTRL_DEADBAND_EN to force |error| <= DEADBAND to zero.
// Revision : 1.0 - initial release
// ============================================================================
module p_controller_pwm #(
    parameter int PWM_W     = 10,
    parameter int KP_SHIFT  = 4,
    parameter int DUTY_BIAS = 512,
    parameter int DEADBAND  = 8
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic [11:0]      sensor_reading,
    input  logic             reading_valid,
    input  logic [11:0]      setpoint,
    input  logic [7:0]       kp,
    output logic [PWM_W-1:0] duty,
    output logic             duty_valid,
    output logic             pwm_out
);

    localparam logic [PWM_W-1:0]   c_CNT_MAX  = '1;
    localparam logic [PWM_W-1:0]   c_CNT_ONE  = (PWM_W)'(1);
    localparam logic signed [22:0] c_BIAS     = 23'(DUTY_BIAS);
    localparam logic signed [22:0] c_DUTY_MAX = 23'((1 << PWM_W) - 1);

    // ------------------------------------------------------------------
    // Rising-edge detect on reading_valid: a held-high strobe yields a
    // single capture.
    // ------------------------------------------------------------------
    logic r_valid_d;
    logic w_capture;

    assign w_capture = reading_valid & ~r_valid_d;

    // ------------------------------------------------------------------
    // Stage 1 datapath: 13-bit signed error, optionally deadbanded
    // ------------------------------------------------------------------
    logic signed [12:0] w_err_raw;
    logic signed [12:0] w_err;

    assign w_err_raw = $signed({1'b0, setpoint}) - $signed({1'b0, sensor_reading});

`ifdef P_CTRL_DEADBAND_EN
    localparam logic [12:0] c_DEADBAND = 13'(DEADBAND);
    logic [12:0] w_err_mag;

    // |err| never exceeds 4095, so negation cannot overflow 13 bits.
    assign w_err_mag = w_err_raw[12] ? unsigned'(-w_err_raw) : unsigned'(w_err_raw);
    assign w_err     = (w_err_mag <= c_DEADBAND) ? '0 : w_err_raw;
`else
    // DEADBAND has no effect in this build.
    localparam int c_unused_deadband = DEADBAND;
    assign w_err = w_err_raw;
`endif

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic               r_v1, r_v2, r_v3;
    logic signed [12:0] r_err;
    logic [7:0]         r_kp;
    logic signed [21:0] r_prod;
    logic signed [22:0] r_sum;
    logic [PWM_W-1:0]   r_duty;
    logic               r_duty_valid;

    logic signed [21:0] w_prod_shr;
    logic signed [22:0] w_sum;
    logic [PWM_W-1:0]   w_duty_sat;

    assign w_prod_shr = r_prod >>> KP_SHIFT;
    // Sign-extend to 23 bits before adding the bias; the range cannot overflow.
    assign w_sum      = $signed({w_prod_shr[21], w_prod_shr}) + c_BIAS;

    always_comb begin
        w_duty_sat = r_sum[PWM_W-1:0];
        if (r_sum[22]) begin
            w_duty_sat = '0;
        end else if (r_sum > c_DUTY_MAX) begin
            w_duty_sat = c_CNT_MAX;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_valid_d    <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            r_err        <= '0;
            r_kp         <= '0;
            r_prod       <= '0;
            r_sum        <= '0;
            r_duty       <= '0;
            r_duty_valid <= 1'b0;
        end else begin
            r_valid_d    <= reading_valid;
            r_v1         <= w_capture;
            r_v2         <= r_v1;
            r_v3         <= r_v2;
            r_duty_valid <= r_v3;
            if (w_capture) begin
                r_err <= w_err;
                r_kp  <= kp;
            end
            if (r_v1) begin
                // kp is zero-extended so the multiply stays signed.
                r_prod <= r_err * $signed({1'b0, r_kp});
            end
            if (r_v2) begin
                r_sum <= w_sum;
            end
            if (r_v3) begin
                r_duty <= w_duty_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM generator. duty_active is reloaded only on the wrap edge; it
    // samples r_duty as it stands before that edge, so a duty update
    // landing on the same edge waits for the next period.
    // ------------------------------------------------------------------
    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty_active;
    logic             r_pwm;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_cnt         <= '0;
            r_duty_active <= '0;
            r_pwm         <= 1'b0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
            if (r_cnt == c_CNT_MAX) begin
                r_duty_active <= r_duty;
            end
            r_pwm <= (r_cnt < r_duty_active);
        end
    end

    assign duty       = r_duty;
    assign duty_valid = r_duty_valid;
    assign pwm_out    = r_pwm;

endmodule
`default_nettype wire
